ahb2apb_bridge_gen: RTL and testbench
=====================================

Name: ahb2apb_bridge_gen

Overview:
Parametrised AHB-Lite slave to APB3 master bridge. It supersedes the fixed 3-slave bridge: slave count, widths and address map are configurable, and it adds PREADY wait states, PSLVERR and decode-error propagation as a two-cycle AHB ERROR, and an APB timeout. It sits between the AHB master model and the APB interface in the top-level bench, in place of the current bridge.

Parameters:
ADDR_WIDTH, 32, width of Haddr/Paddr
DATA_WIDTH, 32, width of Hwdata/Hrdata/Pwdata/Prdata
NUM_SLAVES, 3, number of APB select lines
BASE_ADDR, 32'h8000_0000, start of the APB region
SLV_SIZE_LOG2, 28, log2 of the bytes per slave window
TIMEOUT, 16, maximum ACCESS cycles with Pready low before ERROR; 0 disables the timeout

Ports:
Hclk  in  1  clock, rising edge
Hresetn  in  1  asynchronous active-low reset
Hwrite  in  1  AHB direction, 1 = write
Hreadyin  in  1  AHB HREADY seen by all slaves
Htrans  in  2  AHB transfer type
Haddr  in  ADDR_WIDTH  AHB address
Hwdata  in  DATA_WIDTH  AHB write data (data phase)
Prdata  in  DATA_WIDTH  APB read data
Pready  in  1  APB ready
Pslverr  in  1  APB slave error
Pselx  out  NUM_SLAVES  one-hot APB select
Penable  out  1  APB enable
Pwrite  out  1  APB direction
Paddr  out  ADDR_WIDTH  APB address (registered)
Pwdata  out  DATA_WIDTH  APB write data (registered)
Hreadyout  out  1  bridge HREADY
Hresp  out  2  00 = OKAY, 01 = ERROR
Hrdata  out  DATA_WIDTH  AHB read data

Behaviour:
- Reset (asynchronous, effective immediately):
  - Pselx, Penable, Pwrite, Paddr, Pwdata, Hrdata = 0.
  - Hresp = 00, Hreadyout = 1, state = IDLE, timeout counter = 0.
  - Reset mid-transfer drops Pselx/Penable at once; there is no completion.
- Valid transfer: Hreadyin = 1 and Htrans is NONSEQ (10) or SEQ (11). IDLE (00) and BUSY (01) are ignored.
- Decode: off = Haddr - BASE_ADDR; idx = off >> SLV_SIZE_LOG2.
  - Hit when Haddr >= BASE_ADDR and idx < NUM_SLAVES; otherwise decode error.
- Address capture: a valid transfer is sampled only in a cycle where Hreadyout = 1, i.e. IDLE, the completing ACCESS cycle, or ERR2. On that edge latch Haddr, Hwrite and idx.
- State machine:
  - IDLE: Hreadyout = 1. Valid hit -> CAPT; valid miss -> ERR1.
  - CAPT: Hreadyout = 0. Register Hwdata into Pwdata (writes only), drive Paddr and Pwrite -> SETUP.
  - SETUP: Pselx[idx] = 1, Penable = 0, Hreadyout = 0 -> ACCESS.
  - ACCESS: Pselx held, Penable = 1. Counter increments each cycle Pready = 0.
    - Pready = 1 & Pslverr = 0: Hreadyout = 1, Hresp = 00, Hrdata = Prdata (combinational in this cycle). Next state is IDLE, or CAPT/ERR1 if a new transfer is sampled.
    - Pready = 1 & Pslverr = 1, or counter reaches TIMEOUT (TIMEOUT != 0): Hreadyout = 0, Hresp = 01 -> ERR1.
  - ERR1: Pselx = 0, Penable = 0, Hresp = 01, Hreadyout = 0 -> ERR2.
  - ERR2: Hresp = 01, Hreadyout = 1. A new valid transfer is sampled as in IDLE.
- Counter clears on entry to SETUP. On timeout, Pselx and Penable deassert on the next edge, so the APB transfer is abandoned.
- Outside ACCESS-complete, Hrdata holds its last value. Paddr, Pwrite and Pwdata hold between transfers.
- Latency: with Pready tied 1, a transfer completes 3 cycles after the address phase (CAPT, SETUP, ACCESS). Each Pready-low cycle adds 1.
- Back-to-back: a transfer sampled in the completing ACCESS cycle goes straight to CAPT, with no IDLE cycle.
- Pselx is never more than one-hot. Penable is only ever 1 in ACCESS.

Test Plan:
- Write 0x8000_0010 <- 0xDEAD_BEEF, Pready = 1 -> Pselx = 001 in SETUP and ACCESS, Paddr = 0x8000_0010, Pwdata = 0xDEAD_BEEF, Pwrite = 1; Hreadyout low 2 cycles, then high with Hresp = 00.
- Read 0x9000_0004, Pready low 2 ACCESS cycles, Prdata = 0x1234_5678 -> Pselx = 010, Hreadyout low 4 cycles, completion cycle Hrdata = 0x1234_5678, Hresp = 00.
- Write to 0xA000_0000 with Pslverr = 1 at Pready -> Pselx = 100; Hresp = 01 for two cycles, Hreadyout 0 then 1.
- Read 0x4000_0000 (decode miss) -> no Pselx/Penable activity; ERR1 then ERR2, Hresp = 01.
- Pready held 0, TIMEOUT = 16 -> after 16 ACCESS cycles, Penable and Pselx drop and the two-cycle ERROR response follows.
- Back-to-back writes to 0x8000_0000 and 0x8000_0004 -> second CAPT directly follows the first ACCESS. Hresetn asserted in a later ACCESS -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ahb2apb_bridge_gen_if.sv
// AHB-Lite slave side and APB3 master side of the bridge, grouped as one bundle.
interface ahb2apb_bridge_gen_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_SLAVES = 3
);
   // AHB side
   logic                  Hwrite;
   logic                  Hreadyin;
   logic [1:0]            Htrans;
   logic [ADDR_WIDTH-1:0] Haddr;
   logic [DATA_WIDTH-1:0] Hwdata;
   logic                  Hreadyout;
   logic [1:0]            Hresp;
   logic [DATA_WIDTH-1:0] Hrdata;
   // APB side
   logic [DATA_WIDTH-1:0] Prdata;
   logic                  Pready;
   logic                  Pslverr;
   logic [NUM_SLAVES-1:0] Pselx;
   logic                  Penable;
   logic                  Pwrite;
   logic [ADDR_WIDTH-1:0] Paddr;
   logic [DATA_WIDTH-1:0] Pwdata;

   // Bridge view: AHB slave that masters the APB bus
   modport slave (
      input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr,
      output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hresp, Hrdata
   );

   // Environment view: AHB master model plus APB slave model
   modport master (
      output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready, Pslverr,
      input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hresp, Hrdata
   );
endinterface

// File: rtl/ahb2apb_bridge_gen.sv
// Parametrised AHB-Lite to APB3 bridge with wait states, slave error, decode
// error and ACCESS timeout, all reported as a two-cycle AHB ERROR.
module ahb2apb_bridge_gen #(
   parameter int unsigned           ADDR_WIDTH    = 32,
   parameter int unsigned           DATA_WIDTH    = 32,
   parameter int unsigned           NUM_SLAVES    = 3,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(32'h8000_0000),
   parameter int unsigned           SLV_SIZE_LOG2 = 28,
   parameter int unsigned           TIMEOUT       = 16
) (
   input logic                  Hclk,
   input logic                  Hresetn,
   ahb2apb_bridge_gen_if.slave  bus
);

   localparam int unsigned IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE, S_CAPT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic                  hwrite_q, hwrite_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [NUM_SLAVES-1:0] pselx_q, pselx_d;
   logic                  penable_q, penable_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

   logic [ADDR_WIDTH-1:0] off_c, win_c;
   logic                  valid_c, hit_c, done_c, tmo_c, err_c, hready_c, sample_c;

   // Address decode and transfer qualification
   always_comb begin
      off_c    = bus.Haddr - BASE_ADDR;
      win_c    = off_c >> SLV_SIZE_LOG2;
      hit_c    = (bus.Haddr >= BASE_ADDR) && (win_c < ADDR_WIDTH'(NUM_SLAVES));
      valid_c  = bus.Hreadyin && ((bus.Htrans == 2'b10) || (bus.Htrans == 2'b11));
      done_c   = (state_q == S_ACCESS) && bus.Pready && !bus.Pslverr;
      tmo_c    = (TIMEOUT != 0) && (state_q == S_ACCESS) && !bus.Pready &&
                 (cnt_q == CNT_W'(TMO_LAST));
      err_c    = (state_q == S_ACCESS) && ((bus.Pready && bus.Pslverr) || tmo_c);
      hready_c = (state_q == S_IDLE) || (state_q == S_ERR2) || done_c;
      sample_c = hready_c && valid_c;
   end

   // State register
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_ERR2: begin
            if (valid_c) state_d = hit_c ? S_CAPT : S_ERR1;
            else         state_d = S_IDLE;
         end
         S_CAPT:  state_d = S_SETUP;
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (done_c) begin
               if (valid_c) state_d = hit_c ? S_CAPT : S_ERR1;
               else         state_d = S_IDLE;
            end else if (err_c) begin
               state_d = S_ERR1;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   // AHB response outputs and next values of the APB/datapath registers
   always_comb begin
      haddr_d   = haddr_q;
      hwrite_d  = hwrite_q;
      idx_d     = idx_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      pselx_d   = pselx_q;
      penable_d = penable_q;
      cnt_d     = cnt_q;
      hrdata_d  = hrdata_q;

      bus.Hreadyout = hready_c;
      bus.Hresp     = (err_c || (state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
      bus.Hrdata    = done_c ? bus.Prdata : hrdata_q;

      if (sample_c) begin
         haddr_d  = bus.Haddr;
         hwrite_d = bus.Hwrite;
         idx_d    = IDX_W'(win_c);
      end

      unique case (state_q)
         S_CAPT: begin
            paddr_d   = haddr_q;
            pwrite_d  = hwrite_q;
            if (hwrite_q) pwdata_d = bus.Hwdata;
            pselx_d   = NUM_SLAVES'(1) << idx_q;
            penable_d = 1'b0;
            cnt_d     = '0;
         end
         S_SETUP: penable_d = 1'b1;
         S_ACCESS: begin
            if (done_c || err_c) begin
               pselx_d   = '0;
               penable_d = 1'b0;
               if (done_c) hrdata_d = bus.Prdata;
            end else if (!bus.Pready) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            pselx_d   = '0;
            penable_d = 1'b0;
         end
      endcase
   end

   // Datapath and APB output registers
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         haddr_q   <= '0;
         hwrite_q  <= 1'b0;
         idx_q     <= '0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pselx_q   <= '0;
         penable_q <= 1'b0;
         cnt_q     <= '0;
         hrdata_q  <= '0;
      end else begin
         haddr_q   <= haddr_d;
         hwrite_q  <= hwrite_d;
         idx_q     <= idx_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         pselx_q   <= pselx_d;
         penable_q <= penable_d;
         cnt_q     <= cnt_d;
         hrdata_q  <= hrdata_d;
      end
   end

   assign bus.Pselx   = pselx_q;
   assign bus.Penable = penable_q;
   assign bus.Pwrite  = pwrite_q;
   assign bus.Paddr   = paddr_q;
   assign bus.Pwdata  = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_gen.sv
// Directed bench for ahb2apb_bridge_gen: write, waited read, slave error,
// decode misses, timeout, back-to-back and reset in ACCESS.
module tb_ahb2apb_bridge_gen;

   logic Hclk;
   logic Hresetn;
   int   n_checks;
   int   n_errors;

   ahb2apb_bridge_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3)) bus ();

   ahb2apb_bridge_gen dut (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .bus     (bus)
   );

   // 10 ns clock
   initial begin
      Hclk = 1'b0;
      forever #5 Hclk = ~Hclk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [2:0] psel, input logic pen,
                          input logic hrdy, input logic [1:0] hresp);
      chk({tag, ".Pselx"},     64'(bus.Pselx),     64'(psel));
      chk({tag, ".Penable"},   64'(bus.Penable),   64'(pen));
      chk({tag, ".Hreadyout"}, 64'(bus.Hreadyout), 64'(hrdy));
      chk({tag, ".Hresp"},     64'(bus.Hresp),     64'(hresp));
   endtask

   task automatic chk_reset(input string tag);
      chk_ctl(tag, 3'b000, 1'b0, 1'b1, 2'b00);
      chk({tag, ".Pwrite"}, 64'(bus.Pwrite), 64'(1'b0));
      chk({tag, ".Paddr"},  64'(bus.Paddr),  64'(32'h0));
      chk({tag, ".Pwdata"}, 64'(bus.Pwdata), 64'(32'h0));
      chk({tag, ".Hrdata"}, 64'(bus.Hrdata), 64'(32'h0));
   endtask

   // Move to 1 ns after the next rising edge (input drive point)
   task automatic next_cycle();
      @(posedge Hclk);
      #1;
   endtask

   // Let combinational outputs settle before sampling
   task automatic settle();
      #2;
   endtask

   task automatic addr_phase(input logic wr, input logic [31:0] addr);
      bus.Htrans = 2'b10;
      bus.Hwrite = wr;
      bus.Haddr  = addr;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      Hresetn      = 1'b0;
      bus.Hwrite   = 1'b0;
      bus.Hreadyin = 1'b1;
      bus.Htrans   = 2'b00;
      bus.Haddr    = '0;
      bus.Hwdata   = '0;
      bus.Prdata   = '0;
      bus.Pready   = 1'b1;
      bus.Pslverr  = 1'b0;
      #3;
      chk_reset("reset");
      next_cycle();
      next_cycle();
      Hresetn = 1'b1;

      // Write 0x8000_0010 <- 0xDEAD_BEEF, no wait states
      next_cycle(); addr_phase(1'b1, 32'h8000_0010); settle();
      chk_ctl("wr.addr", 3'b000, 1'b0, 1'b1, 2'b00);
      next_cycle(); bus.Htrans = 2'b00; bus.Hwdata = 32'hDEAD_BEEF; settle();
      chk_ctl("wr.capt", 3'b000, 1'b0, 1'b0, 2'b00);
      next_cycle(); settle();
      chk_ctl("wr.setup", 3'b001, 1'b0, 1'b0, 2'b00);
      chk("wr.Paddr",  64'(bus.Paddr),  64'(32'h8000_0010));
      chk("wr.Pwdata", 64'(bus.Pwdata), 64'(32'hDEAD_BEEF));
      chk("wr.Pwrite", 64'(bus.Pwrite), 64'(1'b1));
      next_cycle(); settle();
      chk_ctl("wr.access", 3'b001, 1'b1, 1'b1, 2'b00);
      next_cycle(); bus.Hwdata = 32'h0; settle();
      chk_ctl("wr.idle", 3'b000, 1'b0, 1'b1, 2'b00);
      chk("wr.Paddr_hold", 64'(bus.Paddr), 64'(32'h8000_0010));

      // BUSY to a mapped address is ignored
      addr_phase(1'b1, 32'h8000_0020); bus.Htrans = 2'b01;
      next_cycle(); bus.Htrans = 2'b00; settle();
      chk_ctl("busy.ignored", 3'b000, 1'b0, 1'b1, 2'b00);

      // Read 0x9000_0004 with two wait states
      next_cycle(); addr_phase(1'b0, 32'h9000_0004);
      next_cycle(); bus.Htrans = 2'b00; settle();
      chk_ctl("rd.capt", 3'b000, 1'b0, 1'b0, 2'b00);
      next_cycle(); bus.Pready = 1'b0; settle();
      chk_ctl("rd.setup", 3'b010, 1'b0, 1'b0, 2'b00);
      chk("rd.Paddr",  64'(bus.Paddr),  64'(32'h9000_0004));
      chk("rd.Pwrite", 64'(bus.Pwrite), 64'(1'b0));
      next_cycle(); settle();
      chk_ctl("rd.wait1", 3'b010, 1'b1, 1'b0, 2'b00);
      next_cycle(); settle();
      chk_ctl("rd.wait2", 3'b010, 1'b1, 1'b0, 2'b00);
      next_cycle(); bus.Pready = 1'b1; bus.Prdata = 32'h1234_5678; settle();
      chk_ctl("rd.done", 3'b010, 1'b1, 1'b1, 2'b00);
      chk("rd.Hrdata", 64'(bus.Hrdata), 64'(32'h1234_5678));
      next_cycle(); bus.Prdata = 32'h0; settle();
      chk_ctl("rd.idle", 3'b000, 1'b0, 1'b1, 2'b00);
      chk("rd.Hrdata_hold", 64'(bus.Hrdata), 64'(32'h1234_5678));
      chk("rd.Pwdata_hold", 64'(bus.Pwdata), 64'(32'hDEAD_BEEF));

      // Write 0xA000_0000 answered with PSLVERR
      next_cycle(); addr_phase(1'b1, 32'hA000_0000);
      next_cycle(); bus.Htrans = 2'b00; bus.Hwdata = 32'h0BAD_F00D;
      next_cycle(); settle();
      chk_ctl("slverr.setup", 3'b100, 1'b0, 1'b0, 2'b00);
      next_cycle(); bus.Pslverr = 1'b1; settle();
      chk_ctl("slverr.access", 3'b100, 1'b1, 1'b0, 2'b01);
      next_cycle(); bus.Pslverr = 1'b0; settle();
      chk_ctl("slverr.err1", 3'b000, 1'b0, 1'b0, 2'b01);
      next_cycle(); settle();
      chk_ctl("slverr.err2", 3'b000, 1'b0, 1'b1, 2'b01);
      next_cycle(); settle();
      chk_ctl("slverr.idle", 3'b000, 1'b0, 1'b1, 2'b00);

      // Decode miss below the region, then a miss above it sampled in ERR2
      addr_phase(1'b0, 32'h4000_0000);
      next_cycle(); bus.Htrans = 2'b00; settle();
      chk_ctl("miss_lo.err1", 3'b000, 1'b0, 1'b0, 2'b01);
      next_cycle(); addr_phase(1'b0, 32'hB000_0000); settle();
      chk_ctl("miss_lo.err2", 3'b000, 1'b0, 1'b1, 2'b01);
      next_cycle(); bus.Htrans = 2'b00; settle();
      chk_ctl("miss_hi.err1", 3'b000, 1'b0, 1'b0, 2'b01);
      next_cycle(); settle();
      chk_ctl("miss_hi.err2", 3'b000, 1'b0, 1'b1, 2'b01);
      next_cycle(); settle();
      chk_ctl("miss_hi.idle", 3'b000, 1'b0, 1'b1, 2'b00);

      // Timeout: Pready held low for 16 ACCESS cycles
      addr_phase(1'b0, 32'h8000_0100);
      next_cycle(); bus.Htrans = 2'b00;
      next_cycle(); bus.Pready = 1'b0; settle();
      chk_ctl("tmo.setup", 3'b001, 1'b0, 1'b0, 2'b00);
      for (int i = 1; i <= 15; i++) begin
         next_cycle(); settle();
         chk_ctl($sformatf("tmo.wait%0d", i), 3'b001, 1'b1, 1'b0, 2'b00);
      end
      next_cycle(); settle();
      chk_ctl("tmo.wait16", 3'b001, 1'b1, 1'b0, 2'b01);
      next_cycle(); bus.Pready = 1'b1; settle();
      chk_ctl("tmo.err1", 3'b000, 1'b0, 1'b0, 2'b01);
      next_cycle(); settle();
      chk_ctl("tmo.err2", 3'b000, 1'b0, 1'b1, 2'b01);

      // Back-to-back writes, then reset during the second ACCESS
      next_cycle(); addr_phase(1'b1, 32'h8000_0000);
      next_cycle(); bus.Htrans = 2'b00; bus.Hwdata = 32'h1111_1111;
      next_cycle(); settle();
      chk("b2b.Pwdata1", 64'(bus.Pwdata), 64'(32'h1111_1111));
      next_cycle(); addr_phase(1'b1, 32'h8000_0004); settle();
      chk_ctl("b2b.access1", 3'b001, 1'b1, 1'b1, 2'b00);
      next_cycle(); bus.Htrans = 2'b00; bus.Hwdata = 32'h2222_2222; settle();
      chk_ctl("b2b.capt2", 3'b000, 1'b0, 1'b0, 2'b00);
      next_cycle(); bus.Pready = 1'b0; settle();
      chk_ctl("b2b.setup2", 3'b001, 1'b0, 1'b0, 2'b00);
      chk("b2b.Paddr2",  64'(bus.Paddr),  64'(32'h8000_0004));
      chk("b2b.Pwdata2", 64'(bus.Pwdata), 64'(32'h2222_2222));
      next_cycle(); settle();
      chk_ctl("b2b.access2", 3'b001, 1'b1, 1'b0, 2'b00);
      Hresetn = 1'b0;
      #1;
      chk_reset("rst_access");
      next_cycle();
      Hresetn = 1'b1;
      bus.Pready = 1'b1;
      next_cycle(); settle();
      chk_ctl("post_rst.idle", 3'b000, 1'b0, 1'b1, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
